// File: rtl/rf_read_sequencer.sv
// Holds a batch of up to 12 register-read requests, issues selector-chosen ports to the replicated RF BRAM lanes,
// collects the 1-cycle read data and returns the whole batch. Optional write bypass: RF_BYPASS_EN.
module rf_read_sequencer #(
    parameter int NUM_BRAMS = 4,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [11:0]                   req_mask,
    input  logic [12*ADDR_W-1:0]          req_addr,
    output logic [11:0]                   r_read_mask,
    output logic [11:0]                   r_done_mask,
    input  logic [4*NUM_BRAMS*2-1:0]      r_selected_id,
    output logic [NUM_BRAMS*2-1:0]        bram_ren,
    output logic [NUM_BRAMS*2*ADDR_W-1:0] bram_raddr,
    input  logic [NUM_BRAMS*2*DATA_W-1:0] bram_rdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [12*DATA_W-1:0]          rsp_data,
    input  logic [1:0]                    wr_en,
    input  logic [2*ADDR_W-1:0]           wr_addr,
    input  logic [2*DATA_W-1:0]           wr_data,
    output logic [1:0]                    dbg_state
);
    localparam int NP = 12;
    localparam int NL = NUM_BRAMS * 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RESP} state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
    state_t              state_q;
    logic [NP-1:0]       mask_q, done_q, infl_q;
    logic [ADDR_W-1:0]   addr_q [NP];
    logic [DATA_W-1:0]   data_q [NP];
    logic [NL-1:0]       lane_vld_q;
    logic [3:0]          lane_id_q [NL];

    logic [NP-1:0]       pend, iss;
    logic [NL-1:0]       lane_vld;
    logic [3:0]          lane_id [NL];
    logic [ADDR_W-1:0]   lane_addr [NL];
    logic                last_issue;
    logic [NP-1:0]       cap_en;
    logic [DATA_W-1:0]   cap_val [NP];

    // A lane is only trusted for a pending port not already claimed by a lower lane this cycle.
    always_comb begin
        pend     = mask_q & ~(done_q | infl_q);
        iss      = '0;
        lane_vld = '0;
        for (int k = 0; k < NL; k++) begin
            lane_id[k]   = r_selected_id[k*4 +: 4];
            lane_addr[k] = '0;
            if (state_q == S_READ && lane_id[k] < 4'd12) begin
                if (pend[lane_id[k]] && !iss[lane_id[k]]) begin
                    lane_vld[k]      = 1'b1;
                    iss[lane_id[k]]  = 1'b1;
                    for (int p = 0; p < NP; p++)
                        if (lane_id[k] == 4'(p)) lane_addr[k] = addr_q[p];
                end
            end
        end
        last_issue = ((pend & ~iss) == '0);
    end

`ifdef RF_BYPASS_EN
    logic [NP-1:0]     byp_hit;
    logic [DATA_W-1:0] byp_val [NP];
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    always_comb begin
        cap_en = '0;
        for (int p = 0; p < NP; p++) cap_val[p] = '0;
        for (int k = 0; k < NL; k++)
            for (int p = 0; p < NP; p++)
                if (lane_vld_q[k] && lane_id_q[k] == 4'(p)) begin
                    cap_en[p]  = 1'b1;
                    cap_val[p] = bram_rdata[k*DATA_W +: DATA_W];
                end
`ifdef RF_BYPASS_EN
        byp_hit = '0;
        for (int p = 0; p < NP; p++) begin
            byp_val[p] = '0;
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr_q[p]) begin
                    byp_hit[p] = 1'b1;
                    byp_val[p] = wr_data[w*DATA_W +: DATA_W];
                end
            if (byp_hit[p]) cap_val[p] = byp_val[p];
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            done_q     <= '0;
            infl_q     <= '0;
            lane_vld_q <= '0;
            for (int p = 0; p < NP; p++) begin
                addr_q[p] <= '0;
                data_q[p] <= '0;
            end
            for (int k = 0; k < NL; k++) lane_id_q[k] <= '0;
        end else begin
            lane_vld_q <= lane_vld;
            for (int k = 0; k < NL; k++) lane_id_q[k] <= lane_id[k];
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        mask_q <= req_mask;
                        done_q <= '0;
                        infl_q <= '0;
                        for (int p = 0; p < NP; p++) begin
                            addr_q[p] <= req_addr[p*ADDR_W +: ADDR_W];
                            data_q[p] <= '0;
                        end
                        state_q <= (req_mask != '0) ? S_READ : S_RESP;
                    end
                end
                S_READ, S_DRAIN: begin
                    done_q <= done_q | cap_en;
                    infl_q <= (infl_q & ~cap_en) | iss;
                    for (int p = 0; p < NP; p++)
                        if (cap_en[p]) data_q[p] <= cap_val[p];
                    if (state_q == S_DRAIN)  state_q <= S_RESP;
                    else if (last_issue)     state_q <= S_DRAIN;
                end
                S_RESP: begin
                    if (rsp_ready) state_q <= S_IDLE;
`ifdef RF_BYPASS_EN
                    else
                        for (int p = 0; p < NP; p++)
                            if (mask_q[p] && byp_hit[p]) data_q[p] <= byp_val[p];
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bram_raddr = '0;
        rsp_data   = '0;
        for (int k = 0; k < NL; k++) bram_raddr[k*ADDR_W +: ADDR_W] = lane_addr[k];
        for (int p = 0; p < NP; p++) rsp_data[p*DATA_W +: DATA_W] = data_q[p];
    end

    assign bram_ren    = lane_vld;
    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign r_read_mask = mask_q;
    assign r_done_mask = done_q | infl_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rf_read_sequencer.sv
// Directed and randomized batches against rf_read_sequencer with a BRAM/selector environment and a batch-level model.
module tb_rf_read_sequencer;
    localparam int NUM_BRAMS = 4;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int NP        = 12;
    localparam int NL        = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid, req_ready;
    logic [11:0]          req_mask;
    logic [NP*ADDR_W-1:0] req_addr;
    logic [11:0]          r_read_mask, r_done_mask;
    logic [4*NL-1:0]      r_selected_id;
    logic [NL-1:0]        bram_ren;
    logic [NL*ADDR_W-1:0] bram_raddr;
    logic [NL*DATA_W-1:0] bram_rdata;
    logic                 rsp_valid, rsp_ready;
    logic [NP*DATA_W-1:0] rsp_data;
    logic [1:0]           wr_en;
    logic [2*ADDR_W-1:0]  wr_addr;
    logic [2*DATA_W-1:0]  wr_data;
    logic [1:0]           dbg_state;

    rf_read_sequencer #(.NUM_BRAMS(NUM_BRAMS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask), .req_addr(req_addr),
        .r_read_mask(r_read_mask), .r_done_mask(r_done_mask), .r_selected_id(r_selected_id),
        .bram_ren(bram_ren), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // RF contents and 1-cycle-latency BRAM lanes
    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] rd_q [NL];
    always @(posedge clk)
        for (int k = 0; k < NL; k++)
            if (bram_ren[k]) rd_q[k] <= mem[bram_raddr[k*ADDR_W +: ADDR_W]];
    always_comb
        for (int k = 0; k < NL; k++) bram_rdata[k*DATA_W +: DATA_W] = rd_q[k];

    // Selector: 0 = lowest pending ports first, unused lanes 0; 1 = id 0 everywhere; 2 = lanes 0-3 random garbage
    int         sel_mode;
    logic [3:0] rnd_id [NL];
    always @(posedge clk)
        for (int k = 0; k < NL; k++) rnd_id[k] <= 4'($urandom_range(0, 15));
    always_comb begin
        logic [11:0] pend;
        int n;
        pend = r_read_mask & ~r_done_mask;
        r_selected_id = '0;
        n = 0;
        if (sel_mode == 2) begin
            for (int k = 0; k < 4; k++) r_selected_id[k*4 +: 4] = rnd_id[k];
            n = 4;
        end
        if (sel_mode != 1)
            for (int p = 0; p < NP; p++)
                if (pend[p] && n < NL) begin
                    r_selected_id[n*4 +: 4] = 4'(p);
                    n++;
                end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-batch expectation: requested ports read mem[addr], write-lane hits override when bypass is built in.
    function automatic logic [383:0] model_rsp(input logic [11:0] m, input logic [71:0] a);
        logic [383:0] r;
        r = '0;
        for (int p = 0; p < NP; p++)
            if (m[p]) begin
                r[p*32 +: 32] = mem[a[p*6 +: 6]];
`ifdef RF_BYPASS_EN
                if (wr_en[0] && wr_addr[5:0] == a[p*6 +: 6])  r[p*32 +: 32] = wr_data[31:0];
                if (wr_en[1] && wr_addr[11:6] == a[p*6 +: 6]) r[p*32 +: 32] = wr_data[63:32];
`endif
            end
        return r;
    endfunction

    // With lowest-first selection, each issue cycle takes min(8, remaining) ports.
    function automatic int exp_latency(input logic [11:0] m);
        int c;
        c = $countones(m);
        return (c == 0) ? 1 : (c + 7) / 8 + 2;
    endfunction

    function automatic logic [7:0] exp_ren(input logic [11:0] m, input int cyc);
        int c;
        c = $countones(m) - 8 * (cyc - 1);
        if (c <= 0) return 8'h00;
        if (c >= 8) return 8'hff;
        return 8'((1 << c) - 1);
    endfunction

    function automatic logic [71:0] rand_addr();
        return {8'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic run_batch(input string tag, input logic [11:0] m, input logic [71:0] a, input int mode,
                             input bit timed, input int hold);
        logic [383:0] exp;
        logic [7:0]   ren1, ren2;
        int           lat, nren;
        bit           got, busy_ready;
        @(negedge clk);
        sel_mode  = mode;
        req_valid = 1'b1;
        req_mask  = m;
        req_addr  = a;
        chk({tag, "_accept_ready"}, 384'(req_ready), 384'(1));
        exp = model_rsp(m, a);
        @(negedge clk);
        lat = 1; nren = 0; ren1 = '0; ren2 = '0; got = 0; busy_ready = 0;
        while (lat <= 60 && !got) begin
            if (rsp_valid) got = 1;
            else begin
                if (lat == 1) ren1 = bram_ren;
                if (lat == 2) ren2 = bram_ren;
                nren += $countones(bram_ren);
                if (req_ready) busy_ready = 1;
                req_valid = 1'($urandom);
                req_mask  = 12'($urandom);
                req_addr  = rand_addr();
                @(negedge clk);
                lat++;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_rsp_seen"}, 384'(got), 384'(1));
        chk({tag, "_busy_ready"}, 384'(busy_ready), 384'(0));
        if (got) begin
            if (timed) begin
                chk({tag, "_latency"}, 384'(lat), 384'(exp_latency(m)));
                chk({tag, "_ren_t1"}, 384'(ren1), 384'(exp_ren(m, 1)));
                chk({tag, "_ren_t2"}, 384'(ren2), 384'(exp_ren(m, 2)));
            end
            chk({tag, "_reads"}, 384'(nren), 384'($countones(m)));
            chk({tag, "_data"}, rsp_data, exp);
            for (int h = 0; h < hold; h++) begin
                rsp_ready = 1'b0;
                @(negedge clk);
                chk({tag, "_hold_ctl"}, 384'({rsp_valid, req_ready, bram_ren}), 384'({1'b1, 1'b0, 8'h00}));
                chk({tag, "_hold_data"}, rsp_data, exp);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk({tag, "_after_hs"}, 384'({rsp_valid, req_ready}), 384'(2'b01));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 384'({req_ready, rsp_valid, bram_ren, r_read_mask, r_done_mask}),
            384'({1'b1, 1'b0, 8'h00, 12'h000, 12'h000}));
        chk({tag, "_raddr"}, 384'(bram_raddr), 384'(0));
        chk({tag, "_rsp_data"}, rsp_data, 384'(0));
    endtask

    initial begin
        logic [71:0] a;
        logic [11:0] m;
        int          md;
        reset = 1'b0; req_valid = 1'b0; req_mask = '0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = '0; wr_addr = '0; wr_data = '0; sel_mode = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // Full batch, addr i = i, data = 3*addr
        a = '0;
        for (int i = 0; i < NP; i++) a[i*6 +: 6] = 6'(i);
        run_batch("full", 12'hfff, a, 0, 1, 0);
        run_batch("empty", 12'h000, rand_addr(), 0, 1, 0);
        run_batch("single_id0", 12'h001, rand_addr(), 1, 1, 0);
        run_batch("stall5", 12'($urandom), rand_addr(), 0, 1, 5);

        // Reset while eight reads are in flight
        @(negedge clk);
        sel_mode = 0; req_valid = 1'b1; req_mask = 12'hfff; req_addr = rand_addr();
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_inflight", 384'(bram_ren), 384'(8'hff));
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst_async");
        @(negedge clk);
        chk_reset_outputs("midrst_held");
        reset = 1'b1;
        run_batch("post_reset", 12'hfff, rand_addr(), 0, 1, 1);

        // Both write lanes hit port 2's address throughout the batch
        a = rand_addr();
        a[2*6 +: 6] = 6'd5;
        mem[5] = 32'h1234_5678;
        wr_en = 2'b11; wr_addr = {6'd5, 6'd5}; wr_data = {32'h0000_000b, 32'h0000_000a};
        run_batch("bypass", 12'h004, a, 0, 1, 2);
`ifdef RF_BYPASS_EN
        chk("bypass_port2", 384'(rsp_data[2*32 +: 32]), 384'(32'h0000_000b));
`else
        chk("bypass_port2", 384'(rsp_data[2*32 +: 32]), 384'(32'h1234_5678));
`endif
        wr_en = '0;

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            m  = 12'($urandom);
            md = (n % 2 == 0) ? 0 : 2;
            run_batch($sformatf("rand%0d", n), m, rand_addr(), md, md == 0, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
